// File: rtl/bandit_pkg.sv
// Shared constants for the one-arm-bandit front end: key indices, default debounce length
// and credit ceiling, plus the saturating credit increment used by key_event.
package bandit_pkg;

  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_COIN  = 1;
  localparam int unsigned KEY_SCORE = 2;
  localparam int unsigned NUM_KEYS  = 3;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int unsigned CREDIT_MAX_DEFAULT      = 9;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max_val);
    return (val >= max_val) ? max_val : val + 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw button: 2-FF synchronizer, stability-counter debouncer and rising-edge detect.
// `rise` is high for exactly one cycle after the debounced level goes 0->1.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = bandit_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic rise
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Counter must be able to hold DEBOUNCE_CYCLES-1
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cnt_w_check
    $error("key_debounce: CNT_W too small for DEBOUNCE_CYCLES");
  end

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from the stable one for DEBOUNCE_CYCLES cycles
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and previous stable level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= key;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign rise = stable_q & ~stable_prev_q;

endmodule

// File: rtl/key_event.sv
// Key event front end: three debounced buttons feed pending flags, a fixed-priority
// arbiter (start > coin > score) emits at most one single-cycle pulse per cycle, and an
// optional coin credit counter drives start_constraint.
// Build option: define KEY_EVENT_CREDIT_EN to include the credit counter; otherwise credit
// and start_constraint are tied to 0.
module key_event
  import bandit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned CREDIT_MAX      = CREDIT_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_coin,
  input  logic       key_score,
  output logic       start_p,
  output logic       coin_p,
  output logic       score_p,
  output logic       start_constraint,
  output logic [3:0] credit
);

  // Credit must fit the 4-bit output
  if (CREDIT_MAX > 15) begin : g_credit_max_check
    $error("key_event: CREDIT_MAX must be <= 15");
  end

  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] grant;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_start (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key_start),
    .rise (rise[KEY_START])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_coin (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key_coin),
    .rise (rise[KEY_COIN])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_score (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key_score),
    .rise (rise[KEY_SCORE])
  );

  // Fixed-priority grant; losers stay pending, a rise on a pending key merges into it
  always_comb begin
    grant = '0;
    if (pend_q[KEY_START]) begin
      grant[KEY_START] = 1'b1;
    end else if (pend_q[KEY_COIN]) begin
      grant[KEY_COIN] = 1'b1;
    end else if (pend_q[KEY_SCORE]) begin
      grant[KEY_SCORE] = 1'b1;
    end
    pend_d = (pend_q & ~grant) | rise;
  end

  // Pending event flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign start_p = grant[KEY_START];
  assign coin_p  = grant[KEY_COIN];
  assign score_p = grant[KEY_SCORE];

`ifdef KEY_EVENT_CREDIT_EN
  localparam logic [3:0] CreditMax = 4'(CREDIT_MAX);

  logic [3:0] credit_q, credit_d;

  // Coin adds (saturating), a start with credit consumes one; never both in one cycle
  always_comb begin
    credit_d = credit_q;
    if (coin_p) begin
      credit_d = sat_inc(credit_q, CreditMax);
    end else if (start_p && (credit_q != 4'd0)) begin
      credit_d = credit_q - 4'd1;
    end
  end

  // Credit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= 4'd0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit           = credit_q;
  // Reflects pre-decrement credit during a start pulse
  assign start_constraint = (credit_q == 4'd0);
`else
  assign credit           = 4'd0;
  assign start_constraint = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event with DEBOUNCE_CYCLES=4: table of key presses plus
// hand-written bounce, saturation and reset-mid-debounce sequences; every pulse is matched
// against a scoreboard of expected (cycle, key, credit, constraint) records.
module tb_key_event;

`ifdef KEY_EVENT_CREDIT_EN
  localparam bit CreditOn = 1'b1;
`else
  localparam bit CreditOn = 1'b0;
`endif
  localparam int Lat       = 7;
  localparam int CreditMax = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start, key_coin, key_score;
  logic       start_p, coin_p, score_p, start_constraint;
  logic [3:0] credit;

  key_event #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .CREDIT_MAX     (9)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_start       (key_start),
    .key_coin        (key_coin),
    .key_score       (key_score),
    .start_p         (start_p),
    .coin_p          (coin_p),
    .score_p         (score_p),
    .start_constraint(start_constraint),
    .credit          (credit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [2:0] pulses;
    int       credit;
    logic     sc;
  } exp_t;

  typedef struct {
    logic [2:0] keys;
    int         hold;
    int         exp_credit;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   mc       = 0;

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endfunction

  task automatic monitor();
    logic [2:0] p;
    exp_t       e;
    p = {score_p, coin_p, start_p};
    if (p != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'(p), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_key", int'(p), int'(e.pulses));
        chk("pulse_credit", int'(credit), e.credit);
        chk("pulse_constraint", int'(start_constraint), int'(e.sc));
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_pulse", 0, int'(e.pulses));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  // Queue the pulses a press of `mask` (keys rising now) must produce, in priority order
  task automatic expect_press(input logic [2:0] mask);
    int   k;
    exp_t e;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        e.cyc    = cyc + Lat + k;
        e.pulses = 3'b001 << i;
        e.credit = CreditOn ? mc : 0;
        e.sc     = CreditOn && (mc == 0);
        if (CreditOn) begin
          if (i == 1) mc = (mc < CreditMax) ? mc + 1 : mc;
          else if (i == 0 && mc > 0) mc = mc - 1;
        end
        sb.push_back(e);
        k++;
      end
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    expect_press(mask);
    {key_score, key_coin, key_start} = mask;
    step(hold);
    {key_score, key_coin, key_start} = 3'b000;
    step(16);
  endtask

  initial begin
    // {score,coin,start}, hold, credit afterwards (credit build)
    vecs[0] = '{3'b111, 20, 1};
    vecs[1] = '{3'b010, 20, 2};
    vecs[2] = '{3'b001, 20, 1};
    vecs[3] = '{3'b100, 20, 1};
    vecs[4] = '{3'b011, 20, 1};
    vecs[5] = '{3'b110, 20, 2};
    vecs[6] = '{3'b101, 20, 1};
    vecs[7] = '{3'b001, 20, 0};
    vecs[8] = '{3'b001, 20, 0};
    vecs[9] = '{3'b010, 20, 1};

    rst_n = 1'b0;
    {key_score, key_coin, key_start} = 3'b000;
    step(3);
    chk("rst_start_p", int'(start_p), 0);
    chk("rst_coin_p", int'(coin_p), 0);
    chk("rst_score_p", int'(score_p), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_constraint", int'(start_constraint), CreditOn ? 1 : 0);
    rst_n = 1'b1;
    step(2);

    for (int v = 0; v < 10; v++) begin
      press(vecs[v].keys, vecs[v].hold);
      chk("vec_credit", int'(credit), CreditOn ? vecs[v].exp_credit : 0);
      chk("vec_constraint", int'(start_constraint),
          (CreditOn && vecs[v].exp_credit == 0) ? 1 : 0);
    end

    // Bounce: 2-cycle highs never survive the filter; only the final rise is accepted
    for (int i = 0; i < 5; i++) begin
      key_coin = 1'b1;
      step(2);
      key_coin = 1'b0;
      step(2);
    end
    expect_press(3'b010);
    key_coin = 1'b1;
    step(20);
    key_coin = 1'b0;
    step(16);
    chk("bounce_credit", int'(credit), CreditOn ? 2 : 0);

    // Ten coins saturate the credit, then two legal starts
    for (int i = 0; i < 10; i++) press(3'b010, 10);
    chk("sat_credit", int'(credit), CreditOn ? 9 : 0);
    for (int i = 0; i < 2; i++) press(3'b001, 10);
    chk("after_starts_credit", int'(credit), CreditOn ? 7 : 0);

    // Reset in the middle of debouncing discards the press; the held key is a new rise
    key_coin = 1'b1;
    step(3);
    rst_n = 1'b0;
    mc    = 0;
    step(1);
    chk("midrst_credit", int'(credit), 0);
    chk("midrst_coin_p", int'(coin_p), 0);
    step(1);
    rst_n = 1'b1;
    expect_press(3'b010);
    step(20);
    key_coin = 1'b0;
    step(16);
    chk("midrst_final_credit", int'(credit), CreditOn ? 1 : 0);

    step(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
